// File: rtl/max7219_ctrl.sv
// max7219_ctrl: MAX7219 init sequencer and dirty-digit refresher driving a byte SPI master.
module max7219_ctrl #(
  parameter logic [3:0] INTENSITY   = 4'h8,
  parameter logic [2:0] SCAN_LIMIT  = 3'h7,
  parameter logic [7:0] DECODE_MODE = 8'h00
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       digit_we,
  input  logic [2:0] digit_addr,
  input  logic [7:0] digit_data,
  output logic       spi_start,
  output logic [7:0] spi_data,
  input  logic       spi_busy,
  input  logic       spi_new_data,
  output logic       cs_n,
  output logic       ready
);
  typedef enum logic [2:0] {INIT, IDLE, LOAD_HI, WAIT_HI, LOAD_LO, WAIT_LO, GAP} state_t;
  state_t state;
  logic [2:0] init_idx, sel;
  logic [15:0] frame, init_frame;
  logic gap_cnt, any_dirty;
  logic [7:0] digits [8];
  logic [7:0] dirty, wr_mask, clr_mask;
  always_comb begin
    init_frame = init_idx == 3'd0 ? 16'h0C00 :
                 init_idx == 3'd1 ? 16'h0F00 :
                 init_idx == 3'd2 ? {8'h09, DECODE_MODE} :
                 init_idx == 3'd3 ? {8'h0B, 5'b0, SCAN_LIMIT} :
                 init_idx == 3'd4 ? {8'h0A, 4'b0, INTENSITY} : 16'h0C01;
  end
  // lowest-index dirty digit wins
  always_comb begin
    sel = '0;
    for (int i = 7; i >= 0; i--) if (dirty[i]) sel = 3'(i);
  end
  assign any_dirty = |dirty;
  assign wr_mask   = digit_we ? 8'(1) << digit_addr : 8'h00;
  // a same-cycle write to the captured digit re-sets its dirty bit
  assign clr_mask  = (state == IDLE && any_dirty) ? 8'(1) << sel : 8'h00;
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= INIT;
      init_idx  <= '0;
      frame     <= '0;
      gap_cnt   <= 1'b0;
      cs_n      <= 1'b1;
      spi_start <= 1'b0;
      spi_data  <= '0;
      ready     <= 1'b0;
      dirty     <= 8'hFF;
      for (int i = 0; i < 8; i++) digits[i] <= '0;
    end else begin
      dirty     <= (dirty & ~clr_mask) | wr_mask;
      spi_start <= 1'b0;
      if (digit_we) digits[digit_addr] <= digit_data;
      case (state)
        INIT: begin
          frame <= init_frame;
          cs_n  <= 1'b0;
          state <= LOAD_HI;
        end
        IDLE: if (any_dirty) begin
          frame <= {8'(sel) + 8'd1, digits[sel]};
          cs_n  <= 1'b0;
          state <= LOAD_HI;
        end
        LOAD_HI: if (!spi_busy) begin
          spi_start <= 1'b1;
          spi_data  <= frame[15:8];
          state     <= WAIT_HI;
        end
        WAIT_HI: if (spi_new_data) state <= LOAD_LO;
        LOAD_LO: if (!spi_busy) begin
          spi_start <= 1'b1;
          spi_data  <= frame[7:0];
          state     <= WAIT_LO;
        end
        WAIT_LO: if (spi_new_data) begin
          cs_n    <= 1'b1;
          gap_cnt <= 1'b0;
          state   <= GAP;
        end
        GAP: begin
          gap_cnt <= 1'b1;
          if (gap_cnt) begin
            if (ready) state <= IDLE;
            else if (init_idx == 3'd5) begin
              ready <= 1'b1;
              state <= IDLE;
            end else begin
              init_idx <= init_idx + 3'd1;
              state    <= INIT;
            end
          end
        end
        default: state <= INIT;
      endcase
    end
  end
endmodule

// File: tb/tb_max7219_ctrl.sv
// tb_max7219_ctrl: randomized bench with an SPI byte model and a frame-level reference queue.
module tb_max7219_ctrl;
  logic clk = 0, rst = 1, digit_we = 0, spi_busy = 0, spi_new_data = 0;
  logic [2:0] digit_addr = 0;
  logic [7:0] digit_data = 0;
  logic spi_start, cs_n, ready;
  logic [7:0] spi_data;
  int n_chk = 0, n_fail = 0;
  logic [15:0] exp_q[$], log_q[$];
  int cnt = 0, hi_run = 0, init_done = 0, starts = 0, s0 = 0;
  logic force_busy = 0, have_hi = 0, exp_ready = 0, prev_start = 0, saw_0b = 0, started = 0;
  logic [7:0] hi_byte = 0;
  logic [7:0] pv [8];
  bit pm [8];

  max7219_ctrl dut (
    .clk(clk), .rst(rst), .digit_we(digit_we), .digit_addr(digit_addr),
    .digit_data(digit_data), .spi_start(spi_start), .spi_data(spi_data),
    .spi_busy(spi_busy), .spi_new_data(spi_new_data), .cs_n(cs_n), .ready(ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic got_frame(input logic [15:0] f);
    log_q.push_back(f);
    init_done++;
    if (exp_q.size() == 0) begin
      n_chk++;
      n_fail++;
      $display("FAIL frame_extra: got %04h expected none at %0t", f, $time);
    end else chk("frame", f, exp_q.pop_front());
  endtask

  // SPI byte master model: 16 busy cycles per byte, then a one-cycle done pulse
  initial forever begin
    @(negedge clk);
    if (rst) begin
      cnt = 0; spi_busy = 0; spi_new_data = 0; have_hi = 0; hi_run = 0;
      init_done = 0; exp_ready = 0; prev_start = 0; started = 0;
    end else begin
      if (cs_n === 1'b0 && hi_run > 0 && started) chk("cs_high_gap", hi_run >= 2, 1);
      hi_run = cs_n ? hi_run + 1 : 0;
      spi_new_data = 0;
      if (cnt > 0) begin
        cnt--;
        if (cnt == 0) spi_new_data = 1;
      end
      if (spi_start) begin
        chk("start_while_busy", spi_busy, 0);
        chk("start_cs", cs_n, 0);
        chk("start_width", prev_start, 0);
        cnt = 16;
        starts++;
        started = 1;
        if (!have_hi) begin
          hi_byte = spi_data;
          have_hi = 1;
          if (spi_data == 8'h0B && !ready) saw_0b = 1;
        end else begin
          have_hi = 0;
          got_frame({hi_byte, spi_data});
        end
      end else if (cnt > 0 || have_hi) chk("frame_cs_low", cs_n, 0);
      prev_start = spi_start;
      spi_busy = force_busy || cnt > 0;
      if (init_done >= 6 && hi_run >= 3) exp_ready = 1;
      chk("ready", ready, exp_ready);
    end
  end

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    digit_we = 1; digit_addr = a; digit_data = d;
    @(negedge clk);
    digit_we = 0;
  endtask

  task automatic wait_cs_low();
    int t = 0;
    while (cs_n !== 1'b0 && t < 200) begin @(negedge clk); t++; end
    if (cs_n !== 1'b0) chk("cs_low_timeout", cs_n, 0);
  endtask

  task automatic drain();
    int t = 0;
    while ((exp_q.size() != 0 || hi_run < 4) && t < 3000) begin @(negedge clk); t++; end
    chk("drain", exp_q.size(), 0);
  endtask

  task automatic push_init();
    exp_q.push_back(16'h0C00); exp_q.push_back(16'h0F00); exp_q.push_back(16'h0900);
    exp_q.push_back(16'h0B07); exp_q.push_back(16'h0A08); exp_q.push_back(16'h0C01);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk("rst_cs_n", cs_n, 1);
    chk("rst_spi_start", spi_start, 0);
    chk("rst_spi_data", spi_data, 0);
    chk("rst_ready", ready, 0);
    push_init();
    for (int d = 0; d < 8; d++) exp_q.push_back({8'(d + 1), 8'h00});
    rst = 0;
    drain();
    chk("init_count", log_q.size(), 14);
    chk("init_first", log_q[0], 16'h0C00);
    chk("init_scan", log_q[3], 16'h0B07);
    chk("init_last", log_q[5], 16'h0C01);
    chk("blank_first", log_q[6], 16'h0100);
    chk("blank_last", log_q[13], 16'h0800);
    chk("ready_after_init", ready, 1);
    // single digit write
    log_q.delete();
    exp_q.push_back(16'h045A);
    wr(3, 8'h5A);
    drain();
    chk("single_count", log_q.size(), 1);
    // two writes queued behind an in-flight frame go out lowest first
    exp_q.push_back(16'h0699); exp_q.push_back(16'h0222); exp_q.push_back(16'h0711);
    wr(5, 8'h99);
    wait_cs_low();
    wr(6, 8'h11);
    wr(1, 8'h22);
    drain();
    // rewrite in the capture cycle: old value sent, new value follows
    exp_q.push_back(16'h05A1); exp_q.push_back(16'h05A2);
    wr(4, 8'hA1);
    wr(4, 8'hA2);
    drain();
    // rewrite while frame is in its second byte
    exp_q.push_back(16'h0333); exp_q.push_back(16'h0344);
    s0 = starts;
    wr(2, 8'h33);
    for (int t = 0; t < 200 && starts < s0 + 2; t++) @(negedge clk);
    chk("lo_byte_reached", starts, s0 + 2);
    @(negedge clk);
    wr(2, 8'h44);
    drain();
    // SPI master busy on LOAD_HI entry
    force_busy = 1;
    exp_q.push_back(16'h0877);
    s0 = starts;
    wr(7, 8'h77);
    wait_cs_low();
    repeat (5) @(negedge clk);
    chk("no_start_while_busy", starts, s0);
    force_busy = 0;
    drain();
    chk("one_pulse_per_byte", starts, s0 + 2);
    // randomized bursts landing while a trigger frame is in flight
    for (int it = 0; it < 20; it++) begin
      logic [2:0] a, b;
      logic [7:0] v, w;
      int n;
      a = 3'($urandom_range(0, 7));
      v = 8'($urandom);
      exp_q.push_back({8'(a) + 8'd1, v});
      wr(a, v);
      wait_cs_low();
      for (int i = 0; i < 8; i++) pm[i] = 0;
      n = $urandom_range(0, 5);
      for (int k = 0; k < n; k++) begin
        b = 3'($urandom_range(0, 7));
        w = 8'($urandom);
        pm[b] = 1;
        pv[b] = w;
        wr(b, w);
      end
      for (int i = 0; i < 8; i++) if (pm[i]) exp_q.push_back({8'(i + 1), pv[i]});
      drain();
    end
    // reset mid-frame during the 0x0B init frame; a write during init replaces a blank
    rst = 1;
    repeat (2) @(negedge clk);
    exp_q.delete();
    push_init();
    saw_0b = 0;
    rst = 0;
    for (int t = 0; t < 1000 && !saw_0b; t++) @(negedge clk);
    chk("saw_0b", saw_0b, 1);
    repeat (3) @(negedge clk);
    rst = 1;
    #1;
    chk("midrst_cs_n", cs_n, 1);
    chk("midrst_spi_start", spi_start, 0);
    chk("midrst_spi_data", spi_data, 0);
    chk("midrst_ready", ready, 0);
    repeat (2) @(negedge clk);
    exp_q.delete();
    log_q.delete();
    push_init();
    exp_q.push_back(16'h01C3);
    for (int d = 1; d < 8; d++) exp_q.push_back({8'(d + 1), 8'h00});
    rst = 0;
    wr(0, 8'hC3);
    drain();
    chk("restart_first", log_q[0], 16'h0C00);
    chk("restart_count", log_q.size(), 14);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, %0d checks so far", n_chk);
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/max7219_ctrl.md
MAX7219_CTRL -- requirements
Module: max7219_ctrl

Interface
REQ-001 SHALL have parameter INTENSITY, default 4'h8: value written to the MAX7219 intensity register (0x0A).
REQ-002 SHALL have parameter SCAN_LIMIT, default 3'h7: value written to the scan-limit register (0x0B).
REQ-003 SHALL have parameter DECODE_MODE, default 8'h00: value written to the decode-mode register (0x09).
REQ-004 SHALL have port clk, input, 1: the single clock; all state changes on its rising edge.
REQ-005 SHALL have port rst, input, 1: asynchronous, active-high reset.
REQ-006 SHALL have port digit_we, input, 1: writes digit_data into the digit buffer at digit_addr.
REQ-007 SHALL have port digit_addr, input, 3: digit index 0-7, mapping to MAX7219 register 0x01-0x08.
REQ-008 SHALL have port digit_data, input, 8: segment or BCD byte for the digit.
REQ-009 SHALL have port spi_start, output, 1: one-cycle start pulse to the byte SPI master.
REQ-010 SHALL have port spi_data, output, 8: byte presented to the SPI master, held stable while spi_start is high.
REQ-011 SHALL have port spi_busy, input, 1: SPI master is transferring.
REQ-012 SHALL have port spi_new_data, input, 1: one-cycle pulse when the SPI master completes a byte.
REQ-013 SHALL have port cs_n, output, 1: MAX7219 LOAD/CS, active low; the rising edge latches the frame.
REQ-014 SHALL have port ready, output, 1: high once the init sequence has completed.

Function
REQ-015 SHALL send every frame as 16 bits MSB first: an address byte, then a data byte, each as one SPI master transaction.
REQ-016 SHALL run the init frames in this order after reset: 0x0C00, 0x0F00, 0x09/DECODE_MODE, 0x0B/{5'b0,SCAN_LIMIT}, 0x0A/{4'b0,INTENSITY}, 0x0C01.
REQ-017 SHALL set ready high in the cycle after the last init frame's GAP completes, and keep it high until reset.
REQ-018 SHALL use these states: INIT, IDLE, LOAD_HI, WAIT_HI, LOAD_LO, WAIT_LO, GAP.
REQ-019 SHALL behave in LOAD_HI/LOAD_LO as follows: drive cs_n=0; if spi_busy=0, pulse spi_start for exactly one cycle with spi_data valid, then go to WAIT_x; if spi_busy=1, hold the state with no pulse.
REQ-020 SHALL behave in WAIT_HI/WAIT_LO as follows: keep cs_n=0; on spi_new_data, advance to LOAD_LO or GAP respectively; ignore spi_new_data in any other state.
REQ-021 SHALL, in GAP, drive cs_n=1 for exactly 2 cycles, then go to INIT if init frames remain, otherwise to IDLE.
REQ-022 SHALL keep an 8x8 digit buffer and an 8-bit dirty mask; digit_we writes the buffer and sets dirty[digit_addr]; digit_we is accepted in every state, including during init.
REQ-023 SHALL, in IDLE, select the lowest-index dirty digit, capture its address and data into the frame register, clear its dirty bit, and enter LOAD_HI on the next cycle; with no dirty digit, remain in IDLE with cs_n=1.
REQ-024 SHALL, when digit_we targets the digit being captured in the same cycle, store the new data and leave dirty set (the next frame carries the new value); the captured frame keeps the old data.
REQ-025 SHALL, when writes hit a digit whose frame is in flight, leave that frame unchanged and resend the digit afterward.
REQ-026 SHALL keep cs_n low continuously from LOAD_HI entry through the end of WAIT_LO; no gap between the two bytes.

Reset
REQ-027 SHALL, on rst assertion at any time, immediately force: state INIT, init index 0, cs_n=1, spi_start=0, spi_data=0x00, ready=0, digit buffer all 0x00, dirty mask 0xFF.
REQ-028 SHALL, after reset release, blank all 8 digits (addresses 0x01-0x08, data 0x00, ascending) once the init sequence has completed.
REQ-029 SHALL, when reset is asserted mid-frame, abort the frame (cs_n rises, no partial-frame recovery) and restart the full init sequence.

Verification
REQ-030 SHALL cover: reset release with an SPI model (busy 16 cycles per byte) -> frames 0C00, 0F00, 0900, 0B07, 0A08, 0C01, then 0100...0800; ready rises after the 0C01 GAP.
REQ-031 SHALL cover: after ready, write digit 3=0x5A -> exactly one frame 0x045A; cs_n low across both bytes, then high for 2 cycles.
REQ-032 SHALL cover: writes to digits 6=0x11 and 1=0x22 in the same idle period -> frames 0x0222 then 0x0711.
REQ-033 SHALL cover: writing digit 2=0x33, then digit 2=0x44 while the 0x0333 frame is in WAIT_LO -> 0x0333 completes, followed by 0x0344.
REQ-034 SHALL cover: spi_busy held high for 5 cycles on LOAD_HI entry -> no spi_start until the cycle after busy falls; exactly one pulse per byte.
REQ-035 SHALL cover: rst pulsed during WAIT_HI of the 0x0B07 init frame -> cs_n=1 immediately; the sequence restarts at 0x0C00.
